// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Used by fetch_fifo and if_fetch_unit (optional FETCH_PERF_EN counters live in the top).
package if_pkg;

  localparam int INSN_W = 32;
  localparam logic [INSN_W-1:0] NOP_INSN = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSN_W-1:0] pc_next;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {PC+4, instruction} pairs.
// clear has priority over push and pop; head is read straight from storage registers.
import if_pkg::*;

module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fetch_entry_t           din,
  output fetch_entry_t           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop  && (count_q != '0) && !clear;
  assign do_push = push && ((count_q != CNT_MAX) || do_pop) && !clear;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; consumers gate the head with empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem request FSM, fetch FIFO, branch redirect.
// Define FETCH_PERF_EN to add fetch_cnt/drop_cnt performance counters.
import if_pkg::*;

module if_fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IFID_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InsOut,
  output logic [31:0] PC_out,
  output logic        out_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] drop_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_e     state_q;
  logic [31:0]      pc_q;
  logic             req_q;
  logic [31:0]      addr_q;

  logic [31:0]      pc_plus4;
  logic             push;
  logic             pop;
  logic             drop;
  logic             room;
  logic [CNT_W-1:0] count_after;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  fetch_entry_t     fifo_din;
  fetch_entry_t     fifo_dout;

  assign pc_plus4 = pc_q + 32'd4;
  assign push     = (state_q == ST_WAIT) && imem_ack && !branch_taken;
  assign pop      = !fifo_empty && IFID_write;
  assign drop     = imem_ack && (((state_q == ST_WAIT) && branch_taken) || (state_q == ST_DRAIN));

  assign fifo_din.pc_next = pc_plus4;
  assign fifo_din.insn    = imem_rdata;

  // Space is reserved at issue time: the FIFO occupancy after this edge must leave a free slot.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_after = fifo_count;
    if (push && !pop) count_after = fifo_count + CNT_ONE;
    if (pop && !push) count_after = fifo_count - CNT_ONE;
  end

  assign room = (count_after < DEPTH_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      req_q <= 1'b0;
      if (branch_taken) begin
        pc_q <= branch_target;
        case (state_q)
          ST_WAIT, ST_DRAIN: state_q <= imem_ack ? ST_IDLE : ST_DRAIN;
          default:           state_q <= ST_IDLE;
        endcase
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (room) begin
              req_q   <= 1'b1;
              addr_q  <= pc_q;
              state_q <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (imem_ack) begin
              pc_q <= pc_plus4;
              if (room) begin
                req_q  <= 1'b1;
                addr_q <= pc_plus4;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          ST_DRAIN: begin
            if (imem_ack) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (branch_taken),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign out_valid = !fifo_empty;
  assign InsOut    = fifo_empty ? NOP_INSN : fifo_dout.insn;
  assign PC_out    = fifo_empty ? 32'h0    : fifo_dout.pc_next;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] drop_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (push) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (drop) drop_cnt_q  <= drop_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit plus hand sequences for reset and PC wrap.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifid_write;
  logic        br;
  logic [31:0] br_tgt;
  logic        ack;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] addr;
  logic [31:0] ins_out;
  logic [31:0] pc_out;
  logic        valid;

  logic        rst2_n;
  logic        ack2;
  logic [31:0] rdata2;
  logic        req2;
  logic [31:0] addr2;
  logic [31:0] ins_out2;
  logic [31:0] pc_out2;
  logic        valid2;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, drop_cnt, fetch_cnt2, drop_cnt2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0)) u_dut (
    .clk           (clk),
    .reset         (rst_n),
    .IFID_write    (ifid_write),
    .branch_taken  (br),
    .branch_target (br_tgt),
    .imem_req      (req),
    .imem_addr     (addr),
    .imem_ack      (ack),
    .imem_rdata    (rdata),
    .InsOut        (ins_out),
    .PC_out        (pc_out),
    .out_valid     (valid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .drop_cnt      (drop_cnt)
`endif
  );

  if_fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk           (clk),
    .reset         (rst2_n),
    .IFID_write    (1'b1),
    .branch_taken  (1'b0),
    .branch_target (32'h0),
    .imem_req      (req2),
    .imem_addr     (addr2),
    .imem_ack      (ack2),
    .imem_rdata    (rdata2),
    .InsOut        (ins_out2),
    .PC_out        (pc_out2),
    .out_valid     (valid2)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt     (fetch_cnt2),
    .drop_cnt      (drop_cnt2)
`endif
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        wr;
    logic        br;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic a, logic [31:0] d, logic w, logic b, logic [31:0] t,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ei,
                              logic [31:0] ep);
    vec_t v;
    v.ack = a; v.rdata = d; v.wr = w; v.br = b; v.tgt = t;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_ins = ei; v.e_pc = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_ins, input logic [31:0] e_pc);
    check({tag, " imem_req"},  {31'b0, req},   {31'b0, e_req});
    check({tag, " imem_addr"}, addr,           e_addr);
    check({tag, " out_valid"}, {31'b0, valid}, {31'b0, e_valid});
    check({tag, " InsOut"},    ins_out,        e_ins);
    check({tag, " PC_out"},    pc_out,         e_pc);
  endtask

  localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA000_0001, A2 = 32'hA000_0002;
  localparam logic [31:0] A3 = 32'hA000_0003, A4 = 32'hA000_0004, A5 = 32'hA000_0005;
  localparam logic [31:0] A6 = 32'hA000_0006, A7 = 32'hA000_0007, B0 = 32'hB000_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  initial begin
    // Streaming, stall at DEPTH, redirect while WAIT, redirect with ack+pop, redirect in DRAIN.
    vecs.push_back(mk(0, 0,    1, 0, 0,      1, 32'h000, 0, 0,  0));
    vecs.push_back(mk(0, 0,    1, 0, 0,      0, 32'h000, 0, 0,  0));
    vecs.push_back(mk(1, A0,   1, 0, 0,      1, 32'h004, 1, A0, 32'h004));
    vecs.push_back(mk(0, 0,    1, 0, 0,      0, 32'h004, 0, 0,  0));
    vecs.push_back(mk(1, A1,   1, 0, 0,      1, 32'h008, 1, A1, 32'h008));
    vecs.push_back(mk(0, 0,    1, 0, 0,      0, 32'h008, 0, 0,  0));
    vecs.push_back(mk(1, A2,   1, 0, 0,      1, 32'h00C, 1, A2, 32'h00C));
    vecs.push_back(mk(0, 0,    0, 0, 0,      0, 32'h00C, 1, A2, 32'h00C));
    vecs.push_back(mk(1, A3,   0, 0, 0,      0, 32'h00C, 1, A2, 32'h00C));
    vecs.push_back(mk(0, 0,    0, 0, 0,      0, 32'h00C, 1, A2, 32'h00C));
    vecs.push_back(mk(0, 0,    0, 0, 0,      0, 32'h00C, 1, A2, 32'h00C));
    vecs.push_back(mk(0, 0,    1, 0, 0,      1, 32'h010, 1, A3, 32'h010));
    vecs.push_back(mk(0, 0,    0, 0, 0,      0, 32'h010, 1, A3, 32'h010));
    vecs.push_back(mk(1, A4,   1, 0, 0,      1, 32'h014, 1, A4, 32'h014));
    vecs.push_back(mk(0, 0,    0, 1, 32'h100, 0, 32'h014, 0, 0,  0));
    vecs.push_back(mk(0, 0,    0, 0, 0,      0, 32'h014, 0, 0,  0));
    vecs.push_back(mk(0, 0,    0, 0, 0,      0, 32'h014, 0, 0,  0));
    vecs.push_back(mk(1, JUNK, 0, 0, 0,      0, 32'h014, 0, 0,  0));
    vecs.push_back(mk(0, 0,    0, 0, 0,      1, 32'h100, 0, 0,  0));
    vecs.push_back(mk(0, 0,    0, 0, 0,      0, 32'h100, 0, 0,  0));
    vecs.push_back(mk(1, A5,   0, 0, 0,      1, 32'h104, 1, A5, 32'h104));
    vecs.push_back(mk(0, 0,    0, 0, 0,      0, 32'h104, 1, A5, 32'h104));
    vecs.push_back(mk(1, JUNK, 1, 1, 32'h200, 0, 32'h104, 0, 0,  0));
    vecs.push_back(mk(0, 0,    1, 0, 0,      1, 32'h200, 0, 0,  0));
    vecs.push_back(mk(0, 0,    1, 0, 0,      0, 32'h200, 0, 0,  0));
    vecs.push_back(mk(1, A6,   1, 0, 0,      1, 32'h204, 1, A6, 32'h204));
    vecs.push_back(mk(0, 0,    1, 1, 32'h300, 0, 32'h204, 0, 0,  0));
    vecs.push_back(mk(0, 0,    1, 1, 32'h400, 0, 32'h204, 0, 0,  0));
    vecs.push_back(mk(1, JUNK, 1, 0, 0,      0, 32'h204, 0, 0,  0));
    vecs.push_back(mk(0, 0,    1, 0, 0,      1, 32'h400, 0, 0,  0));
    vecs.push_back(mk(0, 0,    1, 0, 0,      0, 32'h400, 0, 0,  0));

    rst_n = 1'b0; rst2_n = 1'b0;
    ifid_write = 1'b1; br = 1'b0; br_tgt = '0; ack = 1'b0; rdata = '0;
    ack2 = 1'b0; rdata2 = '0;

    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 32'h0, 0, 32'h0, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      ack = vecs[i].ack; rdata = vecs[i].rdata; ifid_write = vecs[i].wr;
      br = vecs[i].br; br_tgt = vecs[i].tgt;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                 vecs[i].e_ins, vecs[i].e_pc);
      @(negedge clk);
    end
    br = 1'b0; ack = 1'b0; ifid_write = 1'b1;

`ifdef FETCH_PERF_EN
    check("fetch_cnt", fetch_cnt, 32'd7);
    check("drop_cnt",  drop_cnt,  32'd3);
`endif

    // Reset asserted while a request at 0x400 is outstanding; the stale ack lands after release.
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 0, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; ack = 1'b1; rdata = JUNK;
    @(posedge clk);
    #1;
    check_outs("rst_rel", 1, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    ack = 1'b0; rdata = '0;
    @(posedge clk);
    #1;
    check_outs("stale_ack", 0, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    ack = 1'b1; rdata = A7;
    @(posedge clk);
    #1;
    check_outs("post_rst", 1, 32'h4, 1, A7, 32'h4);
`ifdef FETCH_PERF_EN
    check("fetch_cnt_rst", fetch_cnt, 32'd1);
    check("drop_cnt_rst",  drop_cnt,  32'd0);
`endif
    @(negedge clk);
    ack = 1'b0;

    // PC wrap from RESET_PC = 0xFFFFFFFC.
    rst2_n = 1'b1;
    @(posedge clk);
    #1;
    check("wrap req1",  {31'b0, req2}, 32'd1);
    check("wrap addr1", addr2,         32'hFFFF_FFFC);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("wrap req_low", {31'b0, req2}, 32'd0);
    @(negedge clk);
    ack2 = 1'b1; rdata2 = B0;
    @(posedge clk);
    #1;
    check("wrap valid", {31'b0, valid2}, 32'd1);
    check("wrap InsOut", ins_out2, B0);
    check("wrap PC_out", pc_out2,  32'h0);
    check("wrap req2",  {31'b0, req2}, 32'd1);
    check("wrap addr2", addr2,         32'h0);
    @(negedge clk);
    ack2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
